// File: rtl/neuron_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_layer_seq
//  Description : Time-multiplexed fully connected layer. A single signed 8x8
//                MAC evaluates each neuron in turn, fetching weights and the
//                bias from an external synchronous ROM. Each neuron result is
//                passed through a ReLU/quantise stage and streamed out with a
//                valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module neuron_layer_seq #(
    parameter int NUM_INPUTS  = 5,
    parameter int NUM_NEURONS = 4,
    parameter int ADDR_W      = 5,
    parameter int IDX_W       = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*NUM_INPUTS-1:0] in_data,
    output logic [ADDR_W-1:0]       w_addr,
    input  logic [7:0]              w_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_data,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    busy
);

    // Step counter covers j = 0 .. NUM_INPUTS+1 within one neuron.
    localparam int c_J_W = $clog2(NUM_INPUTS + 2);

    localparam logic [c_J_W-1:0] c_NUM_IN_J = c_J_W'(NUM_INPUTS);
    localparam logic [c_J_W-1:0] c_LAST_J   = c_J_W'(NUM_INPUTS + 1);
    localparam logic [IDX_W-1:0] c_LAST_N   = IDX_W'(NUM_NEURONS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_OUT  = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [8*NUM_INPUTS-1:0] r_act;
    logic [15:0]             r_acc;
    logic [c_J_W-1:0]        r_j;
    logic [IDX_W-1:0]        r_neuron;
    logic [ADDR_W-1:0]       r_w_addr;
    logic [7:0]              r_out_data;

    logic [7:0]              w_act;
    logic [15:0]             w_prod;
    logic [15:0]             w_acc_next;
    logic [7:0]              w_quant;

    // Select activation A(j-1) for the weight arriving this cycle.
    always_comb begin
        w_act = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (r_j == c_J_W'(k + 1)) begin
                w_act = r_act[8*k +: 8];
            end
        end
    end

    // Unsigned activation times signed weight; only the low 16 bits matter.
    assign w_prod = $signed({8'd0, w_act}) * $signed({{8{w_data[7]}}, w_data});

    // Accumulator update: nothing on j=0, MAC on weight steps, bias on the last.
    always_comb begin
        w_acc_next = r_acc;
        if (r_j == c_LAST_J) begin
            w_acc_next = r_acc + {{8{w_data[7]}}, w_data};
        end else if (r_j != '0) begin
            w_acc_next = r_acc + w_prod;
        end
    end

    // ReLU and quantise: bit 13 acts as the sign, bits 15:14 are discarded.
    assign w_quant = w_acc_next[13] ? 8'd0 : w_acc_next[13:6];

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: if (in_valid) w_state_next = c_RUN;
            c_RUN:  if (r_j == c_LAST_J) w_state_next = c_OUT;
            c_OUT: begin
                if (out_ready) begin
                    w_state_next = (r_neuron == c_LAST_N) ? c_IDLE : c_RUN;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // Datapath: activation capture, MAC sequencing, ROM addressing, result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_act      <= '0;
            r_acc      <= '0;
            r_j        <= '0;
            r_neuron   <= '0;
            r_w_addr   <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_act    <= in_data;
                        r_acc    <= '0;
                        r_j      <= '0;
                        r_neuron <= '0;
                        r_w_addr <= '0;
                    end
                end
                c_RUN: begin
                    r_acc <= w_acc_next;
                    // Advance through weights to the bias address, then hold.
                    if (r_j < c_NUM_IN_J) begin
                        r_w_addr <= r_w_addr + ADDR_W'(1);
                    end
                    if (r_j == c_LAST_J) begin
                        r_out_data <= w_quant;
                        r_j        <= '0;
                    end else begin
                        r_j <= r_j + c_J_W'(1);
                    end
                end
                c_OUT: begin
                    if (out_ready && (r_neuron != c_LAST_N)) begin
                        r_neuron <= r_neuron + IDX_W'(1);
                        r_j      <= '0;
                        r_acc    <= '0;
                        // Neuron blocks are contiguous: the next block starts
                        // right after the bias address still held here.
                        r_w_addr <= r_w_addr + ADDR_W'(1);
                    end
                end
                default: begin
                    r_j <= '0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign busy      = (r_state != c_IDLE);
    assign out_valid = (r_state == c_OUT);
    assign out_data  = r_out_data;
    assign out_idx   = r_neuron;
    assign w_addr    = r_w_addr;

endmodule
`default_nettype wire

// File: tb/tb_neuron_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_neuron_layer_seq
//  Description : Self-checking bench for neuron_layer_seq with a ROM model,
//                a behavioural layer model and randomized layers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_layer_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [39:0] in_data;
    logic [4:0]  w_addr;
    logic [7:0]  w_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_idx;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;

    logic signed [7:0] rom [32];

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] idx;
    } res_t;

    res_t exp_q[$];

    neuron_layer_seq #(
        .NUM_INPUTS (5),
        .NUM_NEURONS(4),
        .ADDR_W     (5),
        .IDX_W      (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data one cycle after the address.
    always @(posedge clk) w_data <= rom[w_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Reference: weighted sum plus bias, modulo 2^16.
    function automatic logic [15:0] model_acc(input int n, input logic [39:0] v);
        int s;
        s = int'(rom[n*6+5]);
        for (int k = 0; k < 5; k++) s += int'(v[8*k +: 8]) * int'(rom[n*6+k]);
        return 16'(s);
    endfunction

    function automatic logic [7:0] quant(input logic [15:0] a);
        return a[13] ? 8'd0 : a[13:6];
    endfunction

    function automatic int exp_addr(input int t);
        int n;
        int j;
        if (t >= 32) return 23;
        n = t / 8;
        j = t % 8;
        return (j <= 5) ? n*6 + j : n*6 + 5;
    endfunction

    task automatic enqueue_layer(input logic [39:0] v);
        res_t r;
        for (int n = 0; n < 4; n++) begin
            r.data = quant(model_acc(n, v));
            r.idx  = 2'(n);
            exp_q.push_back(r);
        end
    endtask

    // Compare every valid output cycle against the model queue.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                chk("out_data", 32'(out_data), 32'(exp_q[0].data));
                chk("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Layer with fixed timing checks; optional stall on neuron 3 and a mid-layer in_valid pulse.
    task automatic run_timed(input logic [39:0] v, input int stall, input bit pulse);
        int first_t = -1;
        int n_out   = 0;
        int end_t   = 32 + stall;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = v;
        enqueue_layer(v);
        @(posedge clk);
        for (int t = 0; t <= end_t; t++) begin
            #1;
            in_valid = pulse && (t == 10);
            if (pulse && t == 10) in_data = {$urandom, 8'($urandom)};
            out_ready = !(stall > 0 && t >= 31 && t < 31 + stall);
            @(negedge clk);
            if (t < end_t) chk("w_addr", 32'(w_addr), 32'(exp_addr(t)));
            if (out_valid && first_t < 0) first_t = t;
            if (out_valid && out_ready) n_out++;
            if (pulse && t == 10) chk("in_ready_mid_layer", 32'(in_ready), 32'd0);
            if (t == end_t - 1) chk("in_ready_last_out", 32'(in_ready), 32'd0);
            if (t == end_t) begin
                chk("in_ready_after_layer", 32'(in_ready), 32'd1);
                chk("busy_after_layer", 32'(busy), 32'd0);
                chk("out_valid_after_layer", 32'(out_valid), 32'd0);
            end
            if (t < end_t) @(posedge clk);
        end
        chk("first_valid_latency", 32'(first_t), 32'd7);
        chk("result_count", 32'(n_out), 32'd4);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_random(input logic [39:0] v);
        int cyc = 0;
        @(negedge clk);
        chk("in_ready_before_random", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = v;
        enqueue_layer(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && cyc < 500) begin
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b1;
        chk("random_layer_completes", 32'(cyc < 500), 32'd1);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    initial begin
        logic [39:0] v64;
        logic [39:0] v16;
        logic [39:0] vr;
        v64 = {5{8'd64}};
        v16 = {{4{8'd64}}, 8'd16};
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) rom[i] = 8'sd0;
        rom[0]  = 8'sd64;
        rom[6]  = 8'shC0;
        rom[12] = 8'sd64;
        rom[13] = 8'sd64;
        rom[18] = 8'sd127;
        rom[23] = 8'shF8;

        // Hand-computed values pinning the model.
        chk("model_n0_acc", 32'(model_acc(0, v64)), 32'h1000);
        chk("model_n1_acc", 32'(model_acc(1, v64)), 32'hF000);
        chk("model_n2_acc", 32'(model_acc(2, v64)), 32'h2000);
        chk("model_n0_q", 32'(quant(model_acc(0, v64))), 32'd64);
        chk("model_n1_q", 32'(quant(model_acc(1, v64))), 32'd0);
        chk("model_n2_q", 32'(quant(model_acc(2, v64))), 32'd0);
        chk("model_n3_acc_a16", 32'(model_acc(3, v16)), 32'd2024);
        chk("model_n3_q_a16", 32'(quant(model_acc(3, v16))), 32'd31);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_w_addr", 32'(w_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Directed layers: latency/address/ignored pulse, then backpressure.
        run_timed(v64, 0, 1'b1);
        run_timed(v16, 5, 1'b0);

        // Reset during neuron 1's RUN.
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = v64;
        enqueue_layer(v64);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_w_addr", 32'(w_addr), 32'd0);
        chk("midrst_out_idx", 32'(out_idx), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_output", 32'(out_valid), 32'd0);
        end
        run_timed(v64, 0, 1'b0);

        // Randomized ROM contents, activations and backpressure.
        for (int l = 0; l < 8; l++) begin
            for (int i = 0; i < 24; i++) rom[i] = 8'($urandom);
            if (l == 0) for (int i = 0; i < 24; i++) rom[i] = 8'sh80;
            for (int k = 0; k < 5; k++) vr[8*k +: 8] = 8'($urandom);
            if (l < 2) vr = {5{8'hFF}};
            run_random(vr);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/neuron_layer_seq.md
Name: neuron_layer_seq

Overview:
- Time-multiplexed layer controller: one signed 8x8 MAC computes every neuron of a fully connected layer in turn.
- Replaces one instantiated node per neuron.
- Accepts an activation vector from the previous layer and fetches weights and biases from an external synchronous ROM.
- Applies the team's ReLU/quantise rule and streams one 8-bit result per neuron to the next layer with valid/ready handshakes.

Parameters:
- NUM_INPUTS, 5, activations per vector (fan-in).
- NUM_NEURONS, 4, neurons in this layer.
- ADDR_W, 5, weight ROM address width; must satisfy 2^ADDR_W >= NUM_NEURONS*(NUM_INPUTS+1).
- IDX_W, 2, neuron index width; must satisfy 2^IDX_W >= NUM_NEURONS.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  activation vector valid.
- in_ready  out  1  block can accept a vector.
- in_data  in  8*NUM_INPUTS  activations, unsigned; A0 in bits [7:0].
- w_addr  out  ADDR_W  weight ROM address.
- w_data  in  8  signed ROM word, returned one cycle after w_addr.
- out_valid  out  1  neuron result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  8  quantised neuron output.
- out_idx  out  IDX_W  index of the neuron in out_data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, out_data=0, out_idx=0, w_addr=0, busy=0.
  - Accumulator, counters and activation registers clear.
  - Reset mid-layer abandons the layer; no partial output is emitted.
- ROM layout: neuron n occupies addresses n*(NUM_INPUTS+1)+k.
  - k=0..NUM_INPUTS-1 are weights W0..W(NUM_INPUTS-1).
  - k=NUM_INPUTS is the bias B.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register in_data, set neuron=0, j=0, acc=0, go to RUN.
- State RUN lasts exactly NUM_INPUTS+2 cycles per neuron, indexed by j:
  - If j<=NUM_INPUTS: drive w_addr = neuron*(NUM_INPUTS+1)+j.
  - If 1<=j<=NUM_INPUTS: acc += zero-extended A(j-1) times signed w_data, as a 16-bit two's-complement product.
  - If j=NUM_INPUTS+1: acc += sign-extended w_data (bias, unscaled).
  - On the last RUN cycle, register the quantised value and go to OUT.
- Arithmetic: all sums are modulo 2^16; there is no saturation.
- Quantise rule:
  - If acc[13]==0, out_data=acc[13:6].
  - Otherwise out_data=0.
  - Bits 15:14 are ignored.
- State OUT:
  - out_valid=1; out_idx=neuron.
  - out_data and out_idx hold stable while out_ready=0.
  - On out_valid&out_ready with neuron<NUM_NEURONS-1: neuron+1, j=0, acc=0, back to RUN.
  - On out_valid&out_ready with neuron==NUM_NEURONS-1: go to IDLE, with in_ready=1 on the next cycle.
- in_ready=0 in RUN and OUT; in_data is ignored there.
- w_addr holds its last value outside RUN.
- Latency, defaults with out_ready=1:
  - First out_valid is visible 7 edges after the input handshake edge.
  - Each neuron takes 8 cycles.
  - The full layer takes 32 cycles from handshake to return to IDLE.
- Simultaneous events: in_valid arriving in the same cycle the layer finishes (OUT to IDLE) is not accepted; it is accepted on the following cycle.

Test Plan:
- Reset and handshake timing:
  - Stimulus: release reset, all A=64, ROM neuron0 = {64,0,0,0,0,B=0}.
  - Required: in_ready=1, out_valid=0 before in_valid.
  - Required: first out_valid 7 edges after handshake, out_idx=0, out_data=64 (acc=0x1000).
- Negative result:
  - Stimulus: neuron1 W0=-64, all A=64.
  - Required: acc=0xF000, bit13=1, out_data=0, out_idx=1.
- Bit-13 wrap:
  - Stimulus: neuron2 W0=W1=64, all A=64 (acc=0x2000).
  - Required: out_data=0 even though acc>0.
  - Stimulus: A0=16, W0=127, B=-8 (acc=2024).
  - Required: out_data=31.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles during neuron 3's OUT.
  - Required: out_valid, out_data, out_idx stable; w_addr frozen.
  - Required: after release, return to IDLE and in_ready=1 next cycle.
- Address sequence:
  - Stimulus: monitor w_addr over one layer.
  - Required: 0..5, 6..11, 12..17, 18..23, in order.
  - Required: exactly 4 results, indices 0..3; in_valid pulsed mid-layer is ignored.
- Reset mid-layer:
  - Stimulus: assert reset during neuron 1's RUN.
  - Required: immediate IDLE outputs; no out_valid.
  - Required: next vector restarts at neuron 0, address 0.
